// File: rtl/shiftright_seq.sv
// shiftright_seq: multi-cycle logical/arithmetic right shifter, one bit per clock, start/busy/done handshake
module shiftright_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic               fill;
  // busy and done come straight from the state register, so no input reaches an output combinationally
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      y     <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          y     <= a;
          cnt   <= shamt;
          fill  <= arith & a[WIDTH-1];
          state <= (|shamt) ? SHIFT : DONE;
        end
        SHIFT: begin
          y     <= {fill, y[WIDTH-1:1]};
          cnt   <= cnt - 1'b1;
          state <= (cnt == SHAMT_W'(1)) ? DONE : SHIFT;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shiftright_seq.sv
// tb_shiftright_seq: directed and randomized checks of shiftright_seq against a shift-operator reference model
module tb_shiftright_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        busy, done;
  logic [31:0] y;
  int          n_chk = 0;
  int          n_fail = 0;

  shiftright_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt),
    .arith(arith), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v, input int s, input logic ar);
    return ar ? 32'($signed(v) >>> s) : v >> s;
  endfunction

  task automatic start_op(input logic [31:0] va, input logic [4:0] vs, input logic var_);
    a = va; shamt = vs; arith = var_; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // scr: 0 quiet inputs, 1 random junk on every input while busy, 2 one stray start at the third cycle
  task automatic wait_done(input logic [31:0] ea, input logic [4:0] es, input logic ear,
                           input int scr, input string tag);
    int k = 0;
    logic [31:0] ey = model(ea, int'(es), ear);
    while (done !== 1'b1 && k < 40) begin
      if (scr == 1) begin a = $urandom; shamt = 5'($urandom); arith = 1'($urandom); start = 1'($urandom); end
      if (scr == 2) begin start = (k == 2); if (k == 2) a = 32'hFFFF_FFFF; end
      step();
      k++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(k), 32'(es));
    chk({tag, " y"}, y, ey);
    chk({tag, " busy in done"}, 32'(busy), 32'd1);
    step();
    chk({tag, " done single pulse"}, 32'(done), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " y held"}, y, ey);
    step();
    chk({tag, " no second done"}, 32'(done), 32'd0);
  endtask

  initial begin
    start = 1'b1; a = 32'hDEAD_BEEF; shamt = 5'd7; arith = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset y", y, 32'd0);
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    chk("idle busy", 32'(busy), 32'd0);

    start_op(32'hF000_0000, 5'd4, 1'b0);
    wait_done(32'hF000_0000, 5'd4, 1'b0, 0, "logical");
    chk("logical const", y, 32'h0F00_0000);

    start_op(32'h8000_0000, 5'd31, 1'b1);
    wait_done(32'h8000_0000, 5'd31, 1'b1, 0, "arith31");
    chk("arith31 const", y, 32'hFFFF_FFFF);

    start_op(32'h8000_0000, 5'd31, 1'b0);
    wait_done(32'h8000_0000, 5'd31, 1'b0, 0, "logic31");
    chk("logic31 const", y, 32'h0000_0001);

    start_op(32'h1234_5678, 5'd0, 1'b1);
    wait_done(32'h1234_5678, 5'd0, 1'b1, 0, "zero");

    start_op(32'h0000_0100, 5'd8, 1'b0);
    wait_done(32'h0000_0100, 5'd8, 1'b0, 2, "busyprot");
    chk("busyprot const", y, 32'h0000_0001);

    start_op(32'hA5A5_A5A5, 5'd20, 1'b1);
    repeat (10) step();
    rst = 1'b0;
    step();
    chk("midrst y", y, 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst no done", 32'(done), 32'd0);
    end
    start_op(32'h0000_0002, 5'd1, 1'b0);
    wait_done(32'h0000_0002, 5'd1, 1'b0, 0, "after rst");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rar;
      ra  = $urandom;
      rs  = (i == 0) ? 5'd0 : (i == 1) ? 5'd31 : 5'($urandom);
      rar = (i < 4) ? 1'b1 : 1'($urandom);
      if (i < 4) ra[31] = 1'b1;
      start_op(ra, rs, rar);
      wait_done(ra, rs, rar, 1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
